mem_copy_engine: RTL and testbench

- Bus initiator for the 256x8 data RAM: drives the RAM's MemRead/MemWrite/Address/DataSrc and consumes DataMemOut.
- Performs block COPY (read src, write dst) or block FILL (write constant) of up to 255 bytes.
- Sits beside the core datapath; requests the RAM port through a Req/Grant handshake and signals completion with a one-cycle Done pulse.

---
 rtl/mem_copy_engine.sv | 179 +++++++++++++++++
 tb/tb_mem_copy_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
// Bus initiator for the 256x8 data RAM. Performs a block COPY (read source
// byte, write destination byte, repeat) or a block FILL (write a constant)
// of 0..255 bytes, arbitrating for the RAM port with a ReqMem/GrantMem
// handshake and flagging completion with a one-cycle Done pulse.
//
// Ports:
//   CLK, RESET_N            clock, synchronous active-low reset
//   Start, Mode             begin request (IDLE only), 0 = COPY / 1 = FILL
//   SrcAddr, DstAddr, Len   block description, latched on accepted Start
//   FillVal                 constant for FILL, latched on accepted Start
//   Busy, Done              status: busy outside IDLE, completion pulse
//   ReqMem, GrantMem        RAM port request / grant
//   MemRead, MemWrite       RAM strobes (Mealy, gated by GrantMem)
//   Address, DataSrc        RAM address / write data (0 when not accessing)
//   DataMemOut              combinational RAM read data
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              Start,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [7:0]        Len,
  input  logic [DATA_W-1:0] FillVal,
  output logic              Busy,
  output logic              Done,
  output logic              ReqMem,
  input  logic              GrantMem,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] DataSrc,
  input  logic [DATA_W-1:0] DataMemOut
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [7:0]        remaining;
  logic [DATA_W-1:0] data_buf;
  logic              mode_r;
  logic [DATA_W-1:0] fill_r;

  logic              start_ok;
  logic              bus_ok;
  logic              rd_fire;
  logic              wr_fire;

  assign start_ok = (state == S_IDLE) && Start;

  // The reset is synchronous, but an abort must not let one more access
  // slip out during the cycle in which RESET_N is being held low, so the
  // grant is qualified with RESET_N before it can fire a RAM strobe.
  assign bus_ok = GrantMem && RESET_N;

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; RAM strobes are Mealy on the grant
  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    ReqMem     = 1'b0;
    rd_fire    = 1'b0;
    wr_fire    = 1'b0;

    case (state)
      S_IDLE: begin
        if (Start) begin
          if (Len == 8'd0) begin
            state_next = S_DONE;
          end else if (Mode) begin
            state_next = S_WRITE;
          end else begin
            state_next = S_READ;
          end
        end
      end

      S_READ: begin
        Busy   = 1'b1;
        ReqMem = 1'b1;
        if (bus_ok) begin
          rd_fire    = 1'b1;
          state_next = S_WRITE;
        end
      end

      S_WRITE: begin
        Busy   = 1'b1;
        ReqMem = 1'b1;
        if (bus_ok) begin
          wr_fire = 1'b1;
          if (remaining == 8'd1) begin
            state_next = S_DONE;
          end else if (mode_r) begin
            state_next = S_WRITE;
          end else begin
            state_next = S_READ;
          end
        end
      end

      S_DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Bus drive: idle bus reads as all zeros
  always_comb begin
    MemRead  = rd_fire;
    MemWrite = wr_fire;
    Address  = '0;
    DataSrc  = '0;
    if (rd_fire) begin
      Address = src_ptr;
    end else if (wr_fire) begin
      Address = dst_ptr;
      DataSrc = mode_r ? fill_r : data_buf;
    end
  end

  // Datapath: latch the request, capture read data, advance after each write.
  // Both pointers move together so overlapping copies run in ascending order.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_buf  <= '0;
      mode_r    <= 1'b0;
      fill_r    <= '0;
    end else begin
      if (start_ok) begin
        src_ptr   <= SrcAddr;
        dst_ptr   <= DstAddr;
        remaining <= Len;
        mode_r    <= Mode;
        fill_r    <= FillVal;
      end
      if (rd_fire) begin
        data_buf <= DataMemOut;
      end
      if (wr_fire) begin
        src_ptr   <= src_ptr + ADDR_W'(1);
        dst_ptr   <= dst_ptr + ADDR_W'(1);
        remaining <= remaining - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine
// Self-checking bench for mem_copy_engine. A behavioural RAM answers the
// engine's bus; a reference memory image is updated byte by byte from the
// operation description, and the expected bus transactions are queued for a
// monitor that checks each access as the engine presents it.
module tb_mem_copy_engine;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic              CLK;
  logic              RESET_N;
  logic              Start;
  logic              Mode;
  logic [ADDR_W-1:0] SrcAddr;
  logic [ADDR_W-1:0] DstAddr;
  logic [7:0]        Len;
  logic [DATA_W-1:0] FillVal;
  logic              Busy;
  logic              Done;
  logic              ReqMem;
  logic              GrantMem;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] DataSrc;
  logic [DATA_W-1:0] DataMemOut;

  logic [7:0] ram      [256];
  logic [7:0] seed_mem [256];
  logic [7:0] mram     [256];
  logic       load_ram;

  wr_t        wq[$];
  logic [7:0] rq[$];

  int checks = 0;
  int errors = 0;

  mem_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .Start      (Start),
    .Mode       (Mode),
    .SrcAddr    (SrcAddr),
    .DstAddr    (DstAddr),
    .Len        (Len),
    .FillVal    (FillVal),
    .Busy       (Busy),
    .Done       (Done),
    .ReqMem     (ReqMem),
    .GrantMem   (GrantMem),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .DataSrc    (DataSrc),
    .DataMemOut (DataMemOut)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural RAM: combinational read, write on the clock edge
  assign DataMemOut = ram[Address];

  always @(posedge CLK) begin
    if (load_ram) begin
      ram <= seed_mem;
    end else if (MemWrite) begin
      ram[Address] <= DataSrc;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM access is checked against the next queued expectation
  always @(negedge CLK) begin
    if (MemRead || MemWrite) begin
      checkOutput("rd_wr_exclusive", {31'd0, MemRead & MemWrite}, 32'd0);
      checkOutput("req_during_access", {31'd0, ReqMem}, 32'd1);
    end
    if (MemWrite) begin
      if (wq.size() == 0) begin
        checkOutput("unexpected_write", {24'd0, Address}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = wq.pop_front();
        checkOutput("write_addr", {24'd0, Address}, {24'd0, e.addr});
        checkOutput("write_data", {24'd0, DataSrc}, {24'd0, e.data});
      end
    end else if (MemRead) begin
      if (rq.size() == 0) begin
        checkOutput("unexpected_read", {24'd0, Address}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] a;
        a = rq.pop_front();
        checkOutput("read_addr", {24'd0, Address}, {24'd0, a});
      end
    end else begin
      checkOutput("idle_bus_zero", {16'd0, Address, DataSrc}, 32'd0);
    end
  end

  // One operation: build the reference result and timing, drive it, check it.
  // stall_at/stall_n force a run of GrantMem=0 cycles; rnd randomises grant;
  // poke issues a Start while busy; abort_n resets after that many accesses.
  task automatic applyStimulus(input bit mode, input logic [7:0] src, input logic [7:0] dst,
                               input logic [7:0] len, input logic [7:0] fv,
                               input int stall_at, input int stall_n, input bit rnd,
                               input bit poke, input int abort_n);
    bit         g[1024];
    int         needed;
    int         done_exp;
    int         abort_cyc;
    int         acc;
    int         cc;
    int         done_seen;
    int         done_cnt;
    int         busy_cnt;
    int         bad;
    logic [7:0] a_s;
    logic [7:0] a_d;
    logic [7:0] d;

    // Reference: bytes move strictly in ascending order, one at a time
    for (int i = 0; i < int'(len); i++) begin
      if (abort_n > 0 && i >= abort_n) break;
      a_s = 8'(int'(src) + i);
      a_d = 8'(int'(dst) + i);
      d   = mode ? fv : mram[a_s];
      if (!mode) rq.push_back(a_s);
      mram[a_d] = d;
      wq.push_back('{addr: a_d, data: d});
    end

    for (int c = 0; c < 1024; c++) begin
      if (rnd) g[c] = ($urandom_range(0, 3) != 0);
      else     g[c] = !(stall_at > 0 && c >= stall_at && c < stall_at + stall_n);
    end

    // Every access needs one granted cycle; Done follows the last access
    needed = mode ? int'(len) : 2 * int'(len);
    acc = 0;
    cc  = 1;
    while (acc < needed && cc < 1023) begin
      if (g[cc]) acc++;
      cc++;
    end
    done_exp = cc;

    abort_cyc = 0;
    if (abort_n > 0) begin
      acc = 0;
      for (int c = 1; c < 1023; c++) begin
        if (g[c]) acc++;
        if (acc == abort_n) begin
          abort_cyc = c + 1;
          break;
        end
      end
    end

    Start   = 1'b1;
    Mode    = mode;
    SrcAddr = src;
    DstAddr = dst;
    Len     = len;
    FillVal = fv;
    @(posedge CLK);
    #1;
    Start   = 1'b0;
    Mode    = 1'($urandom);
    SrcAddr = 8'($urandom);
    DstAddr = 8'($urandom);
    Len     = 8'($urandom);
    FillVal = 8'($urandom);

    done_seen = 0;
    done_cnt  = 0;
    busy_cnt  = 0;
    for (int c = 1; c <= done_exp + 3; c++) begin
      GrantMem = g[c];
      if (poke && done_exp >= 3) begin
        Start = (c == 2);
        if (c == 2) begin
          Len  = 8'd7;
          Mode = 1'($urandom);
        end
      end
      if (abort_cyc > 0 && c == abort_cyc)     RESET_N = 1'b0;
      if (abort_cyc > 0 && c == abort_cyc + 1) RESET_N = 1'b1;
      @(negedge CLK);
      if (abort_cyc > 0 && c == abort_cyc + 1) begin
        checkOutput("outputs_after_reset",
                    {11'd0, Busy, Done, ReqMem, MemRead, MemWrite, Address, DataSrc}, 32'd0);
        break;
      end
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        checkOutput("req_in_done", {31'd0, ReqMem}, 32'd0);
        if (done_seen == 0) done_seen = c;
      end
      if (done_seen > 0 && c == done_seen + 1) begin
        checkOutput("idle_after_done", {30'd0, Busy, Done}, 32'd0);
        break;
      end
      @(posedge CLK);
      #1;
    end

    if (abort_cyc > 0) begin
      checkOutput("no_done_on_abort", done_cnt, 32'd0);
    end else begin
      checkOutput("done_cycle", done_seen, done_exp);
      checkOutput("done_pulses", done_cnt, 32'd1);
      checkOutput("busy_cycles", busy_cnt, done_exp);
    end
    checkOutput("writes_drained", wq.size(), 32'd0);
    checkOutput("reads_drained", rq.size(), 32'd0);
    wq.delete();
    rq.delete();

    @(posedge CLK);
    #1;
    Start    = 1'b0;
    GrantMem = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== mram[i]) bad++;
    end
    checkOutput("ram_image", bad, 32'd0);
  endtask

  initial begin
    RESET_N  = 1'b0;
    load_ram = 1'b1;
    Start    = 1'b0;
    Mode     = 1'b0;
    SrcAddr  = '0;
    DstAddr  = '0;
    Len      = '0;
    FillVal  = '0;
    GrantMem = 1'b0;
    for (int i = 0; i < 256; i++) seed_mem[i] = 8'($urandom);
    seed_mem[8'h10] = 8'hA1;
    seed_mem[8'h11] = 8'hB2;
    seed_mem[8'h12] = 8'hC3;
    seed_mem[8'h13] = 8'hD4;
    seed_mem[8'h23] = 8'h3C;
    mram = seed_mem;

    $display("[TB] reset and idle");
    repeat (3) @(posedge CLK);
    #1;
    load_ram = 1'b0;
    GrantMem = 1'b1;
    @(negedge CLK);
    checkOutput("reset_outputs",
                {11'd0, Busy, Done, ReqMem, MemRead, MemWrite, Address, DataSrc}, 32'd0);
    @(posedge CLK);
    #1;
    RESET_N  = 1'b1;
    GrantMem = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("idle_without_start", {30'd0, Busy, ReqMem}, 32'd0);

    $display("[TB] directed operations");
    applyStimulus(1'b0, 8'h10, 8'h80, 8'd4,  8'h00, 0, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 8'h00, 8'h20, 8'd3,  8'h5A, 0, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 8'h40, 8'h50, 8'd0,  8'h00, 0, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 8'h00, 8'h60, 8'd0,  8'hEE, 0, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 8'h00, 8'hFE, 8'd3,  8'h77, 0, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 8'h30, 8'h90, 8'd2,  8'h00, 2, 3, 1'b0, 1'b1, 0);
    applyStimulus(1'b0, 8'hA0, 8'hA1, 8'd6,  8'h00, 0, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 8'h00, 8'hC0, 8'd10, 8'h99, 0, 0, 1'b0, 1'b0, 4);
    applyStimulus(1'b1, 8'h00, 8'hD0, 8'd5,  8'h42, 0, 0, 1'b0, 1'b0, 0);

    $display("[TB] randomized operations");
    for (int n = 0; n < 25; n++) begin
      applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 40)),
                    8'($urandom), 0, 0, 1'b1, 1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
